// File: rtl/topk_pkg.sv
// Shared constants, field offsets and FSM encoding for the top-k front end.
package topk_pkg;
    localparam int META_W       = 88;
    localparam int DATA_W       = 512;
    localparam int ELEM_W       = 32;
    localparam int LANES        = DATA_W / ELEM_W;
    localparam int LANE_W       = $clog2(LANES);
    localparam int PKT_W        = META_W + 1 + DATA_W;
    localparam int LEN_W        = 16;
    localparam int SESS_W       = 16;
    localparam int META_LEN_HI  = 31;
    localparam int META_LEN_LO  = 16;
    localparam int META_SESS_HI = 15;
    localparam int TLAST_BIT    = 512;
    localparam int META_LSB     = TLAST_BIT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SKIP = 2'd2
    } unpack_state_e;

    // A message length must be non-zero and a whole number of elements.
    function automatic logic len_bad(input logic [LEN_W-1:0] len);
        return (len == '0) || (len[1:0] != 2'b00);
    endfunction
endpackage

// File: rtl/pkt_unpacker_if.sv
// Beat input stream and element output stream of the unpacker.
interface pkt_unpacker_if;
    import topk_pkg::*;

    logic [PKT_W-1:0]  s_axis_pkt_TDATA;
    logic              s_axis_pkt_TVALID;
    logic              s_axis_pkt_TREADY;
    logic [ELEM_W-1:0] m_axis_elem_TDATA;
    logic [SESS_W-1:0] m_axis_elem_TUSER;
    logic              m_axis_elem_TLAST;
    logic              m_axis_elem_TVALID;
    logic              m_axis_elem_TREADY;

    modport master (
        output s_axis_pkt_TDATA, s_axis_pkt_TVALID, m_axis_elem_TREADY,
        input  s_axis_pkt_TREADY, m_axis_elem_TDATA, m_axis_elem_TUSER,
        input  m_axis_elem_TLAST, m_axis_elem_TVALID
    );

    modport slave (
        input  s_axis_pkt_TDATA, s_axis_pkt_TVALID, m_axis_elem_TREADY,
        output s_axis_pkt_TREADY, m_axis_elem_TDATA, m_axis_elem_TUSER,
        output m_axis_elem_TLAST, m_axis_elem_TVALID
    );
endinterface

// File: rtl/pkt_unpacker.sv
// Serialises 512b beats into 32b session-tagged elements, one per cycle; element 0 valid 1 cycle after accept.
// Next beat is taken in the last-element cycle only when downstream is ready. PKT_UNPACK_STATS_EN adds counters.
module pkt_unpacker
    import topk_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    pkt_unpacker_if.slave bus,
    output logic          len_err
`ifdef PKT_UNPACK_STATS_EN
    ,
    output logic [31:0]   stat_msgs,
    output logic [31:0]   stat_elems,
    output logic [15:0]   stat_errs
`endif
);

    unpack_state_e     state_q, state_nxt;
    logic [DATA_W-1:0] beat_q;
    logic              beat_last_q;
    logic [LANE_W-1:0] lane_q;
    logic [LEN_W-1:0]  bytes_left_q;
    logic [SESS_W-1:0] session_q;
    logic              first_beat_q;

    logic in_rdy, in_fire, elem_vld, elem_fire, elem_last;
    logic msg_end, lane_last, beat_end, overrun, underrun, discard, bad_len, load, err_nxt;

    wire              in_tlast = bus.s_axis_pkt_TDATA[TLAST_BIT];
    wire [LEN_W-1:0]  in_len   = bus.s_axis_pkt_TDATA[META_LSB+META_LEN_HI : META_LSB+META_LEN_LO];
    wire [SESS_W-1:0] in_sess  = bus.s_axis_pkt_TDATA[META_LSB+META_SESS_HI : META_LSB];
    wire              unused_meta_bits = ^bus.s_axis_pkt_TDATA[PKT_W-1 : META_LSB+META_LEN_HI+1];

    always_comb begin
        msg_end   = (bytes_left_q == LEN_W'(4));
        lane_last = (lane_q == LANE_W'(LANES - 1));
        beat_end  = lane_last || msg_end;
        elem_vld  = (state_q == EMIT) && !rst;
        elem_fire = elem_vld && bus.m_axis_elem_TREADY;
        elem_last = elem_vld && (msg_end || (lane_last && beat_last_q));
        in_rdy    = !rst && ((state_q != EMIT) || (beat_end && bus.m_axis_elem_TREADY));
        in_fire   = in_rdy && bus.s_axis_pkt_TVALID;
        // Byte count ran out on a beat without tlast: the rest of the message is junk.
        overrun   = elem_fire && msg_end && !beat_last_q;
        underrun  = elem_fire && lane_last && beat_last_q && !msg_end;
        discard   = (state_q == SKIP) || overrun;
        bad_len   = first_beat_q && len_bad(in_len);
        load      = in_fire && !discard && !bad_len;
        err_nxt   = overrun || underrun || (in_fire && !discard && bad_len);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE, SKIP: begin
                if (in_fire) state_nxt = load ? EMIT : (in_tlast ? IDLE : SKIP);
            end
            EMIT: begin
                if (in_fire)                    state_nxt = load ? EMIT : (in_tlast ? IDLE : SKIP);
                else if (elem_fire && beat_end) state_nxt = overrun ? SKIP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.s_axis_pkt_TREADY  = in_rdy;
        bus.m_axis_elem_TVALID = elem_vld;
        bus.m_axis_elem_TLAST  = elem_last;
        bus.m_axis_elem_TDATA  = beat_q[lane_q * ELEM_W +: ELEM_W];
        bus.m_axis_elem_TUSER  = session_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q       <= '0;
            beat_last_q  <= 1'b0;
            lane_q       <= '0;
            bytes_left_q <= '0;
            session_q    <= '0;
            first_beat_q <= 1'b1;
            len_err      <= 1'b0;
        end else begin
            len_err <= err_nxt;
            if (in_fire) first_beat_q <= in_tlast;
            if (elem_fire) begin
                if (!beat_end) lane_q <= lane_q + LANE_W'(1);
                // A tlast beat closes the message even if bytes remain.
                bytes_left_q <= (beat_end && beat_last_q) ? '0 : bytes_left_q - LEN_W'(4);
            end
            // Loading a chained beat overrides the end-of-beat update above.
            if (load) begin
                beat_q      <= bus.s_axis_pkt_TDATA[DATA_W-1:0];
                beat_last_q <= in_tlast;
                lane_q      <= '0;
                if (first_beat_q) begin
                    bytes_left_q <= in_len;
                    session_q    <= in_sess;
                end
            end
        end
    end

`ifdef PKT_UNPACK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_msgs  <= '0;
            stat_elems <= '0;
            stat_errs  <= '0;
        end else begin
            if (elem_fire && elem_last) stat_msgs <= stat_msgs + 32'd1;
            if (elem_fire)              stat_elems <= stat_elems + 32'd1;
            if (err_nxt)                stat_errs <= stat_errs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_unpacker.sv
// Randomised bench for pkt_unpacker: expected element stream and error count come from a per-message model.
module tb_pkt_unpacker;
    import topk_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic len_err;
    int   cyc = 0;

    pkt_unpacker_if bus();
`ifdef PKT_UNPACK_STATS_EN
    logic [31:0] stat_msgs, stat_elems;
    logic [15:0] stat_errs;
`endif

    pkt_unpacker dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .len_err (len_err)
`ifdef PKT_UNPACK_STATS_EN
        ,
        .stat_msgs  (stat_msgs),
        .stat_elems (stat_elems),
        .stat_errs  (stat_errs)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [PKT_W-1:0] in_q[$];
    logic [48:0]      exp_q[$];
    int exp_err = 0, err_seen = 0;
    int in_gap_pct = 0, stall_pct = 0;
    bit flush = 1'b1;
    int fire_cnt = 0;
    int fire_cyc[4096];
    int acc_cyc_last = 0;

    // Source and sink driver: handshakes sampled at negedge, new values applied just after posedge.
    initial begin
        bus.s_axis_pkt_TVALID  = 1'b0;
        bus.s_axis_pkt_TDATA   = '0;
        bus.m_axis_elem_TREADY = 1'b0;
        forever begin
            bit acc;
            @(negedge clk);
            acc = bus.s_axis_pkt_TVALID && bus.s_axis_pkt_TREADY;
            if (acc) acc_cyc_last = cyc;
            @(posedge clk);
            #1;
            if (acc || flush) bus.s_axis_pkt_TVALID = 1'b0;
            if (!flush && !bus.s_axis_pkt_TVALID && in_q.size() > 0
                && $urandom_range(99) >= in_gap_pct) begin
                bus.s_axis_pkt_TDATA  = in_q.pop_front();
                bus.s_axis_pkt_TVALID = 1'b1;
            end
            bus.m_axis_elem_TREADY = !flush && ($urandom_range(99) >= stall_pct);
        end
    end

    // Output monitor: scoreboard, hold-while-stalled check, error pulse counting.
    initial begin
        logic [48:0] obs, prev;
        bit prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                obs = {bus.m_axis_elem_TDATA, bus.m_axis_elem_TUSER, bus.m_axis_elem_TLAST};
                if (len_err) err_seen++;
                if (prev_stall) begin
                    chk("hold_vld", 64'(bus.m_axis_elem_TVALID), 64'd1);
                    chk("hold_elem", 64'(obs), 64'(prev));
                end
                if (bus.m_axis_elem_TVALID && bus.m_axis_elem_TREADY) begin
                    chk("elem_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) chk("elem", 64'(obs), 64'(exp_q.pop_front()));
                    fire_cyc[fire_cnt % 4096] = cyc;
                    fire_cnt++;
                end
                prev_stall = bus.m_axis_elem_TVALID && !bus.m_axis_elem_TREADY;
                prev = obs;
            end
        end
    end

    // Queue one message and append what it should produce: elements until the byte count or
    // the tlast beat runs out; one error for bad length, early exhaustion or early tlast.
    task automatic send_msg(input int nb, input int len, input logic [15:0] sess,
                            input bit seq, input int base);
        int rem;
        bit bad, tl;
        logic [95:0]       rnd;
        logic [META_W-1:0] meta;
        logic [DATA_W-1:0] data;
        rem = len;
        bad = (len == 0) || (len % 4 != 0);
        rnd = {$urandom(), $urandom(), $urandom()};
        meta = rnd[META_W-1:0];
        meta[META_LEN_HI:META_LEN_LO] = 16'(len);
        meta[META_SESS_HI:0] = sess;
        if (bad) exp_err++;
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < LANES; l++)
                data[l*32 +: 32] = seq ? 32'(base + b * 16 + l) : $urandom();
            tl = (b == nb - 1);
            in_q.push_back({meta, tl, data});
            if (!bad && rem > 0) begin
                for (int l = 0; l < LANES && rem > 0; l++) begin
                    exp_q.push_back({data[l*32 +: 32], sess, (rem == 4) || (l == LANES - 1 && tl)});
                    rem -= 4;
                end
                if (rem == 0 && !tl) exp_err++;
                else if (tl && rem > 0) begin
                    exp_err++;
                    rem = 0;
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (i < 5000 && (in_q.size() != 0 || exp_q.size() != 0 || bus.s_axis_pkt_TVALID)) begin
            @(posedge clk);
            i++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_drained"}, 64'(in_q.size() + exp_q.size()), 64'd0);
        chk({tag, "_len_err_count"}, 64'(err_seen), 64'(exp_err));
        chk({tag, "_idle_vld"}, 64'(bus.m_axis_elem_TVALID), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s0, len, i;
        repeat (3) @(negedge clk);
        chk("rst_in_rdy", 64'(bus.s_axis_pkt_TREADY), 64'd0);
        chk("rst_out_vld", 64'(bus.m_axis_elem_TVALID), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("rst_vld", 64'(bus.m_axis_elem_TVALID), 64'd0);
        chk("rst_last", 64'(bus.m_axis_elem_TLAST), 64'd0);
        chk("rst_data", 64'(bus.m_axis_elem_TDATA), 64'd0);
        chk("rst_user", 64'(bus.m_axis_elem_TUSER), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("idle_in_rdy", 64'(bus.s_axis_pkt_TREADY), 64'd1);

        // Single 64B message, values 0..15, session 7.
        s0 = fire_cnt;
        send_msg(1, 64, 16'h0007, 1'b1, 0);
        drain("single64");
        chk("single64_first_latency", 64'(fire_cyc[s0 % 4096] - acc_cyc_last), 64'd1);
        chk("single64_no_bubble", 64'(fire_cyc[(s0 + 15) % 4096] - fire_cyc[s0 % 4096]), 64'd15);

        // 192B then 64B back to back: 64 elements without a bubble.
        s0 = fire_cnt;
        send_msg(3, 192, 16'h0011, 1'b1, 0);
        send_msg(1, 64, 16'h0022, 1'b1, 48);
        drain("b2b");
        chk("b2b_no_bubble", 64'(fire_cyc[(s0 + 63) % 4096] - fire_cyc[s0 % 4096]), 64'd63);

        // 128B with 50% downstream stalls.
        stall_pct = 50;
        send_msg(2, 128, 16'h0033, 1'b0, 0);
        drain("stall128");
        stall_pct = 0;

        send_msg(1, 32, 16'h0044, 1'b0, 0);
        drain("len32");
        send_msg(2, 64, 16'h0055, 1'b0, 0);
        drain("early_exhaust");
        send_msg(2, 256, 16'h0066, 1'b0, 0);
        drain("early_tlast");
        send_msg(1, 0, 16'h0077, 1'b0, 0);
        drain("len0");
        send_msg(2, 6, 16'h0088, 1'b0, 0);
        drain("len6");

        // Reset in the middle of a beat, then a fresh message.
        s0 = fire_cnt;
        send_msg(1, 64, 16'h0abc, 1'b0, 0);
        i = 0;
        while (i < 200 && fire_cnt < s0 + 5) begin
            @(posedge clk);
            i++;
        end
        chk("midrst_reached_lane5", 64'(fire_cnt - s0), 64'd5);
        #1;
        flush = 1'b1;
        rst = 1'b1;
        exp_q.delete();
        in_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_vld_after", 64'(bus.m_axis_elem_TVALID), 64'd0);
`ifdef PKT_UNPACK_STATS_EN
        chk("midrst_stat_msgs", 64'(stat_msgs), 64'd0);
        chk("midrst_stat_elems", 64'(stat_elems), 64'd0);
        chk("midrst_stat_errs", 64'(stat_errs), 64'd0);
`endif
        @(posedge clk);
        #1;
        flush = 1'b0;
        send_msg(1, 64, 16'h0def, 1'b0, 0);
        drain("post_rst");

        // Random legal messages with source gaps and sink stalls.
        in_gap_pct = 30;
        stall_pct = 30;
        for (int m = 0; m < 25; m++) begin
            len = 4 * $urandom_range(1, 64);
            send_msg((len + 63) / 64, len, 16'($urandom()), 1'b0, 0);
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
